mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage controller of the five-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. It turns the load/store in the MEM stage into a request/ready transaction on the data-memory port, generates byte enables and replicated store data, and aligns and extends load data. It delivers the finished word as `mem_DM_out` for MEM/WB to capture, and stalls the pipeline while the transaction is outstanding.

## Interface
Parameters:
- `WAIT_LIMIT`, default 255: maximum REQ-state cycles without `dm_ready` before the access is aborted (range 1..255).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_mem_valid` in 1: the MEM-stage instruction is valid.
- `mem_read` in 1: load.
- `mem_write` in 1: store. If both `mem_read` and `mem_write` are set, the access is treated as a load.
- `mem_size` in 2: 00 byte, 01 halfword, 10 and 11 word.
- `mem_unsigned` in 1: zero-extend (1) or sign-extend (0) sub-word loads.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, right-justified.
- `dm_req` out 1: memory request, registered.
- `dm_we` out 1: write strobe, registered.
- `dm_addr` out 32: word address, `{mem_addr[31:2],2'b00}`, registered.
- `dm_wdata` out 32: lane-replicated store data, registered.
- `dm_be` out 4: byte enables, registered.
- `dm_ready` in 1: memory accepted the write, or read data is valid this cycle.
- `dm_rdata` in 32: read word.
- `mem_DM_out` out 32: aligned and extended load result; held until the next access completes.
- `mem_stall` out 1: freeze the PC, IF/ID, ID/EX and EX/MEM registers; combinational.
- `mem_done` out 1: high exactly in the DONE cycle.
- `mem_bus_err` out 1: high in the DONE cycle of a timed-out access.
- `mem_misalign` out 1: high in the DONE cycle of a trapped misaligned access (see Configuration).

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - A request exists when `ex_mem_valid & (mem_read|mem_write)`.
  - On a request: latch size, unsigned and the address low bits; drive the `dm_*` registers; go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `dm_req`=1.
  - When `dm_ready`=1: a load captures the extracted `dm_rdata` into `mem_DM_out`. Then clear `dm_req`/`dm_we` and go to DONE.
  - While `dm_ready`=0, the wait counter increments. When the counter equals `WAIT_LIMIT`: drop `dm_req`, set `mem_DM_out`=0, flag `mem_bus_err`, and go to DONE.
- **DONE**
  - `mem_stall`=0, so the pipeline advances and MEM/WB captures `mem_DM_out`.
  - Always returns to IDLE.
- `mem_stall` = `(IDLE & request) | REQ`.
- Non-memory instructions pass without stalling, and `mem_DM_out` is unchanged.
- **Store byte enables**
  - Byte: `dm_be`=`1<<addr[1:0]`, `dm_wdata`=`{4{wdata[7:0]}}`.
  - Half: `dm_be`=`addr[1]?4'b1100:4'b0011`, `dm_wdata`=`{2{wdata[15:0]}}`.
  - Word: `dm_be`=`4'b1111`, `dm_wdata`=`wdata`.
  - Loads drive `dm_be`=`4'b1111`.
- **Load extraction**
  - Byte: lane `addr[1:0]`, i.e. bits `[8*a+7:8*a]`.
  - Half: lane `addr[1]`.
  - Extend to 32 bits per `mem_unsigned`.
- Stores leave `mem_DM_out` unchanged.

## Timing
- Reset values: state IDLE, wait counter 0, and every output 0: `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_be`, `mem_DM_out`, `mem_done`, `mem_bus_err`, `mem_misalign`.
- Best case with `dm_ready` already high: cycle 0 IDLE (stall=1), cycle 1 REQ (stall=1, ready sampled), cycle 2 DONE (stall=0). That is 2 stall cycles.
- Each `dm_ready`=0 cycle in REQ adds one stall cycle.
- `dm_req` stays high and `dm_addr`, `dm_we`, `dm_wdata`, `dm_be` stay stable until `dm_ready` is sampled or the timeout fires.
- `dm_ready` is ignored outside REQ.
- Back-to-back accesses: DONE, then IDLE sees the next request. The next access starts one cycle after DONE.
- Timeout: the abort occurs on the cycle the counter equals `WAIT_LIMIT`, so REQ lasts `WAIT_LIMIT+1` cycles.
- Reset mid-transaction: outputs clear on the next edge; the pending `dm_ready` is discarded; no DONE is generated.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned request (half with `addr[0]`=1, or word with `addr[1:0]`≠0) issues no bus access.
  - The FSM goes IDLE → DONE, giving 1 stall cycle.
  - In DONE: `mem_misalign`=1 and `mem_DM_out`=0; memory is not written.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are ignored: a half uses only `addr[1]`, a word ignores `addr[1:0]`.
  - `mem_misalign` is tied to 0.

## Test plan
- Word load, `addr`=0x100, `dm_ready` high, `dm_rdata`=0xDEADBEEF → `dm_addr`=0x100, `dm_be`=1111, stall for 2 cycles, DONE with `mem_DM_out`=0xDEADBEEF.
- Signed byte load, `addr`=0x103, `dm_rdata`=0x80FF7F01 → `mem_DM_out`=0xFFFFFF80. Unsigned → 0x00000080.
- Half store, `addr`=0x202, `wdata`=0x1234ABCD, `dm_ready` delayed 3 cycles → `dm_be`=1100 and `dm_wdata`=0xABCDABCD held for all 4 REQ cycles, 5 stall cycles.
- `WAIT_LIMIT`=4, `dm_ready` never asserted → `dm_req` high for 5 cycles, then DONE with `mem_bus_err`=1 and `mem_DM_out`=0.
- `rst` asserted in the 2nd REQ cycle, then `dm_ready`=1 → all outputs 0, no `mem_done`, FSM in IDLE.
- Word load at 0x101 → with the macro: no `dm_req`, 1 stall cycle, `mem_misalign`=1. Without the macro: access at 0x100 and `mem_misalign`=0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage_if
//  Description : Data-memory request/ready bus between the MEM-stage
//                controller (master) and the data memory (slave).
//  Signals     : dm_req    - memory request
//                dm_we     - write strobe
//                dm_addr   - word-aligned byte address
//                dm_wdata  - lane-replicated store data
//                dm_be     - byte enables
//                dm_ready  - write accepted / read data valid
//                dm_rdata  - read word
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    output dm_be,
    input  dm_ready,
    input  dm_rdata
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    input  dm_be,
    output dm_ready,
    output dm_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM-stage controller. Converts the load/store held in
//                EX/MEM into a request/ready transaction on the data-memory
//                bus, builds byte enables and replicated store data, aligns
//                and extends load data, and stalls the pipeline while the
//                transaction is outstanding.
//  Parameters  : WAIT_LIMIT - REQ cycles without dm_ready before abort (1..255)
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                ex_mem_valid     - MEM-stage instruction valid
//                mem_read/write   - load / store (both set => load)
//                mem_size         - 00 byte, 01 half, 1x word
//                mem_unsigned     - zero-extend sub-word loads
//                mem_addr/wdata   - byte address, right-justified store data
//                dm               - data-memory bus (master side)
//                mem_DM_out       - aligned/extended load result (held)
//                mem_stall        - freeze upstream pipeline (combinational)
//                mem_done         - high in the DONE cycle
//                mem_bus_err      - DONE cycle of a timed-out access
//                mem_misalign     - DONE cycle of a trapped misaligned access
//  Options     : MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses skip the bus and report mem_misalign; otherwise the
//                offending low address bits are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_mem_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [1:0]         mem_size,
  input  logic               mem_unsigned,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  mem_access_stage_if.master dm,
  output logic [31:0]        mem_DM_out,
  output logic               mem_stall,
  output logic               mem_done,
  output logic               mem_bus_err,
  output logic               mem_misalign
);

  localparam logic [7:0] c_wait_limit = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_wait_cnt;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lo;
  logic        r_is_load;

  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [3:0]  r_dm_be;
  logic [31:0] r_dm_out;
  logic        r_bus_err;

  logic        w_request;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_stall;
  logic        w_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_request = ex_mem_valid & (mem_read | mem_write);
  assign w_timeout = ~dm.dm_ready & (r_wait_cnt == c_wait_limit);

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misaligned = ((mem_size == 2'b01) & mem_addr[0]) |
                        (mem_size[1] & (mem_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_request) begin
          // Stall starts in the same cycle the request is seen so EX/MEM
          // holds the instruction while the bus registers load.
          w_stall     = 1'b1;
          w_state_nxt = w_misaligned ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (dm.dm_ready || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Store lane steering: sub-word data is replicated across all lanes so the
  // memory only needs the byte enables to pick the right bytes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_wdata;
    if (!mem_read) begin
      case (mem_size)
        2'b00: begin
          w_be    = 4'b0001 << mem_addr[1:0];
          w_wdata = {4{mem_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{mem_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = mem_wdata;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load alignment and extension, using the attributes latched at request
  // time (EX/MEM is frozen, but latching keeps the path independent of it).
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = dm.dm_rdata;
    case (r_lo)
      2'd0:    w_byte = dm.dm_rdata[7:0];
      2'd1:    w_byte = dm.dm_rdata[15:8];
      2'd2:    w_byte = dm.dm_rdata[23:16];
      default: w_byte = dm.dm_rdata[31:24];
    endcase
    w_half = r_lo[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (r_size)
      2'b00:   w_load_data = r_unsigned ? {24'h000000, w_byte}
                                        : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_unsigned ? {16'h0000, w_half}
                                        : {{16{w_half[15]}}, w_half};
      default: w_load_data = dm.dm_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and bus registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lo       <= 2'b00;
      r_is_load  <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'h0;
      r_dm_wdata <= 32'h0;
      r_dm_be    <= 4'b0000;
      r_dm_out   <= 32'h0;
      r_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= 8'd0;
          r_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          r_misalign <= 1'b0;
`endif
          if (w_request) begin
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
            r_lo       <= mem_addr[1:0];
            r_is_load  <= mem_read;
            if (w_misaligned) begin
              // Trapped access: no bus cycle, result forced to zero.
              r_dm_out   <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
              r_misalign <= 1'b1;
`endif
            end else begin
              r_dm_req   <= 1'b1;
              r_dm_we    <= ~mem_read & mem_write;
              r_dm_addr  <= {mem_addr[31:2], 2'b00};
              r_dm_wdata <= w_wdata;
              r_dm_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          if (dm.dm_ready) begin
            if (r_is_load) begin
              r_dm_out <= w_load_data;
            end
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
          end else if (w_timeout) begin
            r_dm_req  <= 1'b0;
            r_dm_we   <= 1'b0;
            r_dm_out  <= 32'h0;
            r_bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          // Status flags are only meaningful for the single DONE cycle.
          r_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          r_misalign <= 1'b0;
`endif
        end
        default: begin
          r_dm_req <= 1'b0;
          r_dm_we  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dm.dm_req    = r_dm_req;
  assign dm.dm_we     = r_dm_we;
  assign dm.dm_addr   = r_dm_addr;
  assign dm.dm_wdata  = r_dm_wdata;
  assign dm.dm_be     = r_dm_be;
  assign mem_DM_out   = r_dm_out;
  assign mem_stall    = w_stall;
  assign mem_done     = w_done;
  assign mem_bus_err  = r_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign = r_misalign;
`else
  assign mem_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage
//                (WAIT_LIMIT = 4). Inputs change on the falling edge and
//                outputs are sampled 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_DM_out;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_bus_err;
  logic        mem_misalign;

  int checks   = 0;
  int failures = 0;

  mem_access_stage_if u_bus ();

  mem_access_stage #(.WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_valid (ex_mem_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .dm           (u_bus),
    .mem_DM_out   (mem_DM_out),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .mem_bus_err  (mem_bus_err),
    .mem_misalign (mem_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    ex_mem_valid = v;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = un;
    mem_addr     = a;
    mem_wdata    = wd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    u_bus.dm_ready = 1'b1;
    u_bus.dm_rdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({u_bus.dm_req, u_bus.dm_we, u_bus.dm_be} !== 6'b0) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=000000", {u_bus.dm_req, u_bus.dm_we, u_bus.dm_be});
    end
    checks++;
    if ({u_bus.dm_addr, u_bus.dm_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL rst_bus got=%h exp=0", {u_bus.dm_addr, u_bus.dm_wdata});
    end
    checks++;
    if ({mem_DM_out, mem_done, mem_bus_err, mem_misalign, mem_stall} !== 36'h0) begin
      failures++;
      $display("FAIL rst_stage got=%h exp=0", {mem_DM_out, mem_done, mem_bus_err, mem_misalign, mem_stall});
    end
    rst = 1'b0;
    u_bus.dm_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_done !== 1'b0 || u_bus.dm_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle got=%b%b exp=00", mem_done, u_bus.dm_req);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_word_load();
    int stalls;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    u_bus.dm_ready = 1'b1;
    u_bus.dm_rdata = 32'hDEAD_BEEF;
    #1;
    stalls = mem_stall ? 1 : 0;
    checks++;
    if (mem_stall !== 1'b1 || u_bus.dm_req !== 1'b0) begin
      failures++;
      $display("FAIL wl_idle got stall=%b req=%b exp stall=1 req=0", mem_stall, u_bus.dm_req);
    end
    @(negedge clk); #1;
    if (mem_stall) stalls++;
    checks++;
    if ({u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
      failures++;
      $display("FAIL wl_req got req=%b we=%b be=%b addr=%h exp 1 0 1111 00000100",
               u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_addr);
    end
    @(negedge clk); #1;
    if (mem_stall) stalls++;
    checks++;
    if (mem_done !== 1'b1 || mem_DM_out !== 32'hDEAD_BEEF || u_bus.dm_req !== 1'b0) begin
      failures++;
      $display("FAIL wl_done got done=%b out=%h req=%b exp 1 deadbeef 0", mem_done, mem_DM_out, u_bus.dm_req);
    end
    checks++;
    if (stalls != 2) begin
      failures++;
      $display("FAIL wl_stalls got=%0d exp=2", stalls);
    end
    idle_inputs();
    u_bus.dm_ready = 1'b0;
    u_bus.dm_rdata = 32'h0;
    @(negedge clk); #1;
    checks++;
    if (mem_done !== 1'b0 || mem_DM_out !== 32'hDEAD_BEEF || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL wl_hold got done=%b out=%h stall=%b exp 0 deadbeef 0", mem_done, mem_DM_out, mem_stall);
    end
  endtask

  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic test_load_extract();
    ld_vec_t v [7];
    int n;
    v[0] = '{32'h103, 2'b00, 1'b0, 32'h80FF_7F01, 32'hFFFF_FF80};
    v[1] = '{32'h103, 2'b00, 1'b1, 32'h80FF_7F01, 32'h0000_0080};
    v[2] = '{32'h101, 2'b00, 1'b0, 32'h80FF_7F01, 32'h0000_007F};
    v[3] = '{32'h102, 2'b00, 1'b0, 32'h80FF_7F01, 32'hFFFF_FFFF};
    v[4] = '{32'h102, 2'b01, 1'b0, 32'h80FF_7F01, 32'hFFFF_80FF};
    v[5] = '{32'h100, 2'b01, 1'b1, 32'h80FF_7F01, 32'h0000_7F01};
    v[6] = '{32'h100, 2'b01, 1'b0, 32'h0000_8001, 32'hFFFF_8001};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, v[i].size, v[i].uns, v[i].addr, 32'h0);
      u_bus.dm_ready = 1'b1;
      u_bus.dm_rdata = v[i].rdata;
      #1;
      n = 0;
      while (!mem_done && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      checks++;
      if (!mem_done || n != 2 || mem_DM_out !== v[i].exp) begin
        failures++;
        $display("FAIL ld_extract[%0d] got out=%h cycles=%0d exp out=%h cycles=2", i, mem_DM_out, n, v[i].exp);
      end
      idle_inputs();
      u_bus.dm_ready = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_store_lanes();
    logic [31:0] a  [3];
    logic [1:0]  sz [3];
    logic [3:0]  be [3];
    logic [31:0] wd [3];
    a[0] = 32'h0000_0201; sz[0] = 2'b00; be[0] = 4'b0010; wd[0] = 32'h5A5A_5A5A;
    a[1] = 32'h0000_0200; sz[1] = 2'b01; be[1] = 4'b0011; wd[1] = 32'hBEEF_BEEF;
    a[2] = 32'h0000_0204; sz[2] = 2'b10; be[2] = 4'b1111; wd[2] = 32'h1234_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, sz[i], 1'b0, a[i], (i == 0) ? 32'h1122_335A : 32'h1234_BEEF);
      u_bus.dm_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_wdata, u_bus.dm_addr} !==
          {1'b1, 1'b1, be[i], wd[i], {a[i][31:2], 2'b00}}) begin
        failures++;
        $display("FAIL st_lanes[%0d] got req=%b we=%b be=%b wd=%h addr=%h exp be=%b wd=%h",
                 i, u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_wdata, u_bus.dm_addr, be[i], wd[i]);
      end
      @(negedge clk);
      idle_inputs();
      u_bus.dm_ready = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_half_store_wait();
    int stalls;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
    u_bus.dm_ready = 1'b0;
    #1;
    stalls = mem_stall ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) u_bus.dm_ready = 1'b1;
      #1;
      if (mem_stall) stalls++;
      checks++;
      if ({u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_wdata, u_bus.dm_addr} !==
          {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0200}) begin
        failures++;
        $display("FAIL hs_req[%0d] got req=%b we=%b be=%b wd=%h addr=%h exp 1 1 1100 abcdabcd 00000200",
                 c, u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_wdata, u_bus.dm_addr);
      end
    end
    @(negedge clk); #1;
    if (mem_stall) stalls++;
    checks++;
    if (mem_done !== 1'b1 || mem_DM_out !== 32'hFFFF_8001 || u_bus.dm_req !== 1'b0 || u_bus.dm_we !== 1'b0) begin
      failures++;
      $display("FAIL hs_done got done=%b out=%h req=%b we=%b exp 1 ffff8001 0 0",
               mem_done, mem_DM_out, u_bus.dm_req, u_bus.dm_we);
    end
    checks++;
    if (stalls != 5) begin
      failures++;
      $display("FAIL hs_stalls got=%0d exp=5", stalls);
    end
    idle_inputs();
    u_bus.dm_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    u_bus.dm_ready = 1'b0;
    u_bus.dm_rdata = 32'h1111_1111;
    @(negedge clk);            // first REQ cycle
    @(negedge clk);            // second REQ cycle
    rst = 1'b1;
    u_bus.dm_ready = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    checks++;
    if ({u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_addr, mem_DM_out, mem_done, mem_bus_err} !== 72'h0) begin
      failures++;
      $display("FAIL rm_clear got req=%b we=%b be=%b addr=%h out=%h done=%b err=%b exp all 0",
               u_bus.dm_req, u_bus.dm_we, u_bus.dm_be, u_bus.dm_addr, mem_DM_out, mem_done, mem_bus_err);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (mem_done !== 1'b0 || u_bus.dm_req !== 1'b0 || mem_stall !== 1'b0) begin
        failures++;
        $display("FAIL rm_idle[%0d] got done=%b req=%b stall=%b exp 0 0 0", c, mem_done, u_bus.dm_req, mem_stall);
      end
    end
    u_bus.dm_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
    u_bus.dm_ready = 1'b1;
    u_bus.dm_rdata = 32'hA5A5_0001;
    @(negedge clk);            // REQ
    @(negedge clk); #1;        // DONE of first access
    checks++;
    if (mem_done !== 1'b1 || mem_DM_out !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL b2b_done1 got done=%b out=%h exp 1 a5a50001", mem_done, mem_DM_out);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0504, 32'h0);
    u_bus.dm_rdata = 32'h5A5A_0002;
    @(negedge clk); #1;        // IDLE sees the next request
    checks++;
    if (mem_stall !== 1'b1 || u_bus.dm_req !== 1'b0 || mem_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got stall=%b req=%b done=%b exp 1 0 0", mem_stall, u_bus.dm_req, mem_done);
    end
    @(negedge clk); #1;        // REQ
    checks++;
    if (u_bus.dm_req !== 1'b1 || u_bus.dm_addr !== 32'h0000_0504) begin
      failures++;
      $display("FAIL b2b_req got req=%b addr=%h exp 1 00000504", u_bus.dm_req, u_bus.dm_addr);
    end
    @(negedge clk); #1;        // DONE of second access
    checks++;
    if (mem_done !== 1'b1 || mem_DM_out !== 32'h5A5A_0002) begin
      failures++;
      $display("FAIL b2b_done2 got done=%b out=%h exp 1 5a5a0002", mem_done, mem_DM_out);
    end
    idle_inputs();
    u_bus.dm_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_timeout();
    int n;
    int reqs;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    u_bus.dm_ready = 1'b0;
    u_bus.dm_rdata = 32'h7777_7777;
    #1;
    n = 0;
    reqs = 0;
    while (!mem_done && n < 30) begin
      @(negedge clk); #1;
      n++;
      if (u_bus.dm_req) reqs++;
    end
    checks++;
    if (!mem_done || reqs != 5) begin
      failures++;
      $display("FAIL to_reqs got done=%b req_cycles=%0d exp 1 5", mem_done, reqs);
    end
    checks++;
    if (mem_bus_err !== 1'b1 || mem_DM_out !== 32'h0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL to_done got err=%b out=%h stall=%b exp 1 00000000 0", mem_bus_err, mem_DM_out, mem_stall);
    end
    idle_inputs();
    @(negedge clk); #1;
    checks++;
    if (mem_bus_err !== 1'b0 || mem_done !== 1'b0) begin
      failures++;
      $display("FAIL to_clear got err=%b done=%b exp 0 0", mem_bus_err, mem_done);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_misalign();
    int n;
    int reqs;
    int stalls;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
    u_bus.dm_ready = 1'b1;
    u_bus.dm_rdata = 32'hCAFE_F00D;
    #1;
    n = 0;
    reqs = 0;
    stalls = mem_stall ? 1 : 0;
    while (!mem_done && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (u_bus.dm_req) begin
        reqs++;
        checks++;
        if (u_bus.dm_addr !== 32'h0000_0100) begin
          failures++;
          $display("FAIL ma_addr got=%h exp=00000100", u_bus.dm_addr);
        end
      end
      if (mem_stall) stalls++;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (!mem_done || reqs != 0 || stalls != 1 || mem_misalign !== 1'b1 || mem_DM_out !== 32'h0) begin
      failures++;
      $display("FAIL ma_trap got done=%b reqs=%0d stalls=%0d mis=%b out=%h exp 1 0 1 1 00000000",
               mem_done, reqs, stalls, mem_misalign, mem_DM_out);
    end
`else
    checks++;
    if (!mem_done || reqs != 1 || stalls != 2 || mem_misalign !== 1'b0 || mem_DM_out !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL ma_noTrap got done=%b reqs=%0d stalls=%0d mis=%b out=%h exp 1 1 2 0 cafef00d",
               mem_done, reqs, stalls, mem_misalign, mem_DM_out);
    end
`endif
    idle_inputs();
    u_bus.dm_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mem_misalign !== 1'b0) begin
      failures++;
      $display("FAIL ma_clear got=%b exp=0", mem_misalign);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    u_bus.dm_ready = 1'b0;
    u_bus.dm_rdata = 32'h0;
    test_reset();
    test_word_load();
    test_load_extract();
    test_store_lanes();
    test_half_store_wait();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
